// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame decoder.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CHECK   = 3'd4,
    DONE    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CHK  = 2'd2,
    ERR_TMO  = 2'd3
  } err_code_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // States in which the decoder is willing to consume a byte from the FIFO.
  function automatic logic state_pops(input state_t s);
    return (s == IDLE) || (s == CMD) || (s == LEN) || (s == PAYLOAD) || (s == CHECK);
  endfunction

  // States in which a partially received frame is outstanding.
  function automatic logic state_in_frame(input state_t s);
    return (s == CMD) || (s == LEN) || (s == PAYLOAD) || (s == CHECK);
  endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout: counts empty-FIFO cycles inside a frame and flags expiry.
module uart_frame_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_active,
  input  logic i_pop,
  input  logic i_empty,
  output logic o_expired
);
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick    = i_active && i_empty && !i_pop;
  // Expiry fires on the cycle the count would reach TIMEOUT_CYCLES.
  assign o_expired = w_tick && (r_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_active || i_pop || o_expired) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// UART frame decoder: SYNC, CMD, LEN, payload, XOR checksum -> one command on valid/ready.
// Optional inter-byte timeout is built in when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned MAX_LEN        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_fifo_empty,
  input  logic [7:0]           i_fifo_data,
  output logic                 o_fifo_read,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [7:0]           o_out_cmd,
  output logic [7:0]           o_out_len,
  output logic [MAX_LEN*8-1:0] o_out_payload,
  output logic                 o_err_pulse,
  output logic [1:0]           o_err_code
);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t               r_state;
  logic [7:0]           r_chk;
  logic [7:0]           r_idx;
  logic [7:0]           r_cmd;
  logic [7:0]           r_len;
  logic [MAX_LEN*8-1:0] r_payload;
  logic                 r_valid;
  logic                 r_err_pulse;
  err_code_t            r_err_code;

  logic                 w_pop;
  logic                 w_tmo_expired;
  logic [7:0]           w_last_idx;

  assign w_pop      = state_pops(r_state) && !i_fifo_empty;
  assign w_last_idx = r_len - 8'd1;

`ifdef UART_FRAME_TIMEOUT_EN
  logic w_in_frame;
  assign w_in_frame = state_in_frame(r_state);

  uart_frame_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_active  (w_in_frame),
    .i_pop     (w_pop),
    .i_empty   (i_fifo_empty),
    .o_expired (w_tmo_expired)
  );
`else
  assign w_tmo_expired = 1'b0;
`endif

  // NOTE: the payload is a small flop bank, not a RAM, so it takes the async reset like the rest.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_chk       <= '0;
      r_idx       <= '0;
      r_cmd       <= '0;
      r_len       <= '0;
      r_payload   <= '0;
      r_valid     <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_err_pulse <= 1'b0;
      if (w_tmo_expired) begin
        r_err_pulse <= 1'b1;
        r_err_code  <= ERR_TMO;
        r_state     <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_pop && (i_fifo_data == SYNC_BYTE)) begin
              r_chk   <= '0;
              r_state <= CMD;
            end
          end
          CMD: begin
            if (w_pop) begin
              r_cmd   <= i_fifo_data;
              r_chk   <= i_fifo_data;
              r_state <= LEN;
            end
          end
          LEN: begin
            if (w_pop) begin
              r_chk <= r_chk ^ i_fifo_data;
              if (i_fifo_data > MAX_LEN_B) begin
                r_err_pulse <= 1'b1;
                r_err_code  <= ERR_LEN;
                r_state     <= IDLE;
              end else begin
                // Clearing here also zeroes the payload of a zero-length frame.
                r_len     <= i_fifo_data;
                r_payload <= '0;
                r_idx     <= '0;
                r_state   <= (i_fifo_data == 8'd0) ? CHECK : PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            if (w_pop) begin
              for (int i = 0; i < int'(MAX_LEN); i++) begin
                if (r_idx == 8'(i)) r_payload[i*8 +: 8] <= i_fifo_data;
              end
              r_chk <= r_chk ^ i_fifo_data;
              r_idx <= r_idx + 8'd1;
              if (r_idx == w_last_idx) r_state <= CHECK;
            end
          end
          CHECK: begin
            if (w_pop) begin
              if (i_fifo_data == r_chk) begin
                r_valid <= 1'b1;
                r_state <= DONE;
              end else begin
                r_err_pulse <= 1'b1;
                r_err_code  <= ERR_CHK;
                r_state     <= IDLE;
              end
            end
          end
          DONE: begin
            if (r_valid && i_out_ready) begin
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_fifo_read   = w_pop;
  assign o_out_valid   = r_valid;
  assign o_out_cmd     = r_cmd;
  assign o_out_len     = r_len;
  assign o_out_payload = r_payload;
  assign o_err_pulse   = r_err_pulse;
  assign o_err_code    = r_err_code;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench for uart_frame_decoder: directed table, corner sequences, random frames vs. a stream parser.
module tb_uart_frame_decoder;
  import uart_frame_pkg::*;

  localparam int         MAX_LEN = 4;
  localparam int         TMO     = 50;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 fifo_empty = 1'b1;
  logic [7:0]           fifo_data = 8'h00;
  logic                 fifo_read;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [7:0]           out_cmd;
  logic [7:0]           out_len;
  logic [MAX_LEN*8-1:0] out_payload;
  logic                 err_pulse;
  logic [1:0]           err_code;

  uart_frame_decoder #(
    .SYNC_BYTE      (SYNC),
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_fifo_empty  (fifo_empty),
    .i_fifo_data   (fifo_data),
    .o_fifo_read   (fifo_read),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_cmd     (out_cmd),
    .o_out_len     (out_len),
    .o_out_payload (out_payload),
    .o_err_pulse   (err_pulse),
    .o_err_code    (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                   is_err;
    logic [7:0]           cmd;
    logic [7:0]           len;
    logic [MAX_LEN*8-1:0] payload;
    logic [1:0]           code;
  } ev_t;

  typedef struct {
    logic [7:0] bytes [8];
    int         n;
    ev_t        exp;
  } vec_t;

  logic [7:0] q [$];
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] bs [$]);
    foreach (bs[i]) q.push_back(bs[i]);
    drive_fifo();
  endtask

  // Called at a falling edge; returns at the next falling edge with the FIFO model updated.
  task automatic step();
    bit pop;
    #1;
    pop = fifo_read;
    @(posedge clk);
    #1;
    if (pop) begin
      if (q.size() == 0) check("pop_on_empty", 1, 0);
      else void'(q.pop_front());
    end
    drive_fifo();
    @(negedge clk);
  endtask

  task automatic wait_event(input int budget, output ev_t ev, output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    ev  = '{1'b0, 8'h00, 8'h00, '0, 2'd0};
    for (int c = 0; c < budget && !got; c++) begin
      cyc = c;
      if (err_pulse || (out_valid && out_ready)) begin
        got = 1'b1;
        ev  = '{err_pulse, out_cmd, out_len, out_payload, err_code};
      end
      step();
    end
  endtask

  task automatic compare_ev(input string tag, input ev_t a, input ev_t e);
    check({tag, ".is_err"}, a.is_err, e.is_err);
    check({tag, ".err_code"}, a.code, e.code);
    if (!e.is_err) begin
      check({tag, ".cmd"}, a.cmd, e.cmd);
      check({tag, ".len"}, a.len, e.len);
      check({tag, ".payload"}, a.payload, e.payload);
    end
  endtask

  // Reference: walk the byte stream with the framing rules and list the resulting events.
  task automatic parse(input logic [7:0] s [$], inout logic [1:0] last_code, output ev_t evs [$]);
    int         i;
    int         len;
    logic [7:0] x;
    ev_t        ev;
    evs = {};
    i   = 0;
    while (i < s.size()) begin
      if (s[i] != SYNC) begin
        i++;
        continue;
      end
      if (i + 2 >= s.size()) break;
      len = int'(s[i+2]);
      ev  = '{1'b0, s[i+1], s[i+2], '0, last_code};
      if (len > MAX_LEN) begin
        last_code = 2'd1;
        ev.is_err = 1'b1;
        ev.code   = last_code;
        evs.push_back(ev);
        i += 3;
        continue;
      end
      if (i + 3 + len >= s.size()) break;
      x = s[i+1] ^ s[i+2];
      for (int k = 0; k < len; k++) begin
        x = x ^ s[i+3+k];
        ev.payload[8*k +: 8] = s[i+3+k];
      end
      if (s[i+3+len] != x) begin
        last_code = 2'd2;
        ev.is_err = 1'b1;
        ev.code   = last_code;
      end
      evs.push_back(ev);
      i += 4 + len;
    end
  endtask

  task automatic gen_stream(input int nframes, output logic [7:0] s [$]);
    logic [7:0] b;
    logic [7:0] chk;
    int         len;
    s = {};
    for (int f = 0; f < nframes; f++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        do b = 8'($urandom); while (b == SYNC);
        s.push_back(b);
      end
      s.push_back(SYNC);
      b = 8'($urandom);
      s.push_back(b);
      chk = b;
      if ($urandom_range(0, 99) < 12) begin
        s.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
        continue;
      end
      len = $urandom_range(0, MAX_LEN);
      s.push_back(8'(len));
      chk = chk ^ 8'(len);
      for (int k = 0; k < len; k++) begin
        b = ($urandom_range(0, 4) == 0) ? SYNC : 8'($urandom);
        s.push_back(b);
        chk = chk ^ b;
      end
      if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      s.push_back(chk);
    end
  endtask

  vec_t       vecs [5];
  ev_t        ev;
  ev_t        snap;
  ev_t        exp_q [$];
  logic [7:0] stream [$];
  logic [1:0] last_code;
  bit         got;
  bit         stalled;
  int         cyc;

  initial begin
    vecs[0] = '{'{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30, 8'h00, 8'h00}, 6,
                '{1'b0, 8'h01, 8'h02, 32'h0000_2211, ERR_NONE}};
    vecs[1] = '{'{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h31, 8'h00, 8'h00}, 6,
                '{1'b1, 8'h00, 8'h00, 32'h0, ERR_CHK}};
    vecs[2] = '{'{8'hA5, 8'h05, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3,
                '{1'b1, 8'h00, 8'h00, 32'h0, ERR_LEN}};
    vecs[3] = '{'{8'hA5, 8'h03, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00}, 4,
                '{1'b0, 8'h03, 8'h00, 32'h0, ERR_LEN}};
    vecs[4] = '{'{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h01, 8'h44, 8'h47}, 8,
                '{1'b0, 8'h02, 8'h01, 32'h0000_0044, ERR_LEN}};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.out_valid", out_valid, 0);
    check("rst.err_pulse", err_pulse, 0);
    check("rst.err_code", err_code, 0);
    check("rst.out_cmd", out_cmd, 0);
    check("rst.out_len", out_len, 0);
    check("rst.out_payload", out_payload, 0);
    check("rst.fifo_read", fifo_read, 0);
    rst_n = 1'b1;
    step();

    // Directed table: good frame, bad checksum, length error, zero length, garbage before sync
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      stream = {};
      for (int k = 0; k < vecs[i].n; k++) stream.push_back(vecs[i].bytes[k]);
      push(stream);
      wait_event(40, ev, got, cyc);
      check($sformatf("vec%0d.got_event", i), got, 1);
      compare_ev($sformatf("vec%0d", i), ev, vecs[i].exp);
      check($sformatf("vec%0d.valid_after", i), out_valid, 0);
      check($sformatf("vec%0d.pulse_after", i), err_pulse, 0);
      check($sformatf("vec%0d.fifo_drained", i), q.size(), 0);
    end
    last_code = 2'd1;

    // Backpressure: two frames queued, consumer stalls 20 cycles
    out_ready = 1'b0;
    push('{8'hA5, 8'h07, 8'h01, 8'h5A, 8'h5C, 8'hA5, 8'h08, 8'h02, 8'hA5, 8'h3C, 8'h93});
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      if (out_valid) got = 1'b1;
      else step();
    end
    check("bp.valid_reached", got, 1);
    for (int c = 0; c < 20; c++) begin
      check("bp.valid_held", out_valid, 1);
      check("bp.no_read", fifo_read, 0);
      check("bp.cmd_stable", out_cmd, 8'h07);
      check("bp.payload_stable", out_payload, 32'h0000_005A);
      step();
    end
    check("bp.fifo_untouched", q.size(), 6);
    out_ready = 1'b1;
    wait_event(5, ev, got, cyc);
    check("bp.first_got", got, 1);
    compare_ev("bp.first", ev, '{1'b0, 8'h07, 8'h01, 32'h0000_005A, last_code});
    wait_event(20, ev, got, cyc);
    check("bp.second_got", got, 1);
    compare_ev("bp.second", ev, '{1'b0, 8'h08, 8'h02, 32'h0000_3CA5, last_code});

    // Random frames against the stream parser, with random backpressure
    gen_stream(40, stream);
    parse(stream, last_code, exp_q);
    push(stream);
    stalled = 1'b0;
    for (int c = 0; c < 6000 && exp_q.size() != 0; c++) begin
      if (stalled) begin
        check("rnd.stall_valid", out_valid, 1);
        check("rnd.stall_cmd", out_cmd, snap.cmd);
        check("rnd.stall_len", out_len, snap.len);
        check("rnd.stall_payload", out_payload, snap.payload);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (err_pulse || (out_valid && out_ready)) begin
        ev = '{err_pulse, out_cmd, out_len, out_payload, err_code};
        compare_ev("rnd", ev, exp_q.pop_front());
      end
      stalled = out_valid && !out_ready;
      snap    = '{1'b0, out_cmd, out_len, out_payload, err_code};
      step();
    end
    check("rnd.all_events_seen", exp_q.size(), 0);
    out_ready = 1'b1;
    repeat (2) step();
    check("rnd.fifo_drained", q.size(), 0);

    // Partial frame stuck in LEN with an empty FIFO
    push('{8'hA5, 8'h01});
`ifdef UART_FRAME_TIMEOUT_EN
    wait_event(80, ev, got, cyc);
    check("tmo.got_event", got, 1);
    check("tmo.is_err", ev.is_err, 1);
    check("tmo.err_code", ev.code, ERR_TMO);
    check("tmo.latency_ok", (cyc >= 50 && cyc <= 54), 1);
    last_code = 2'd3;
    push('{8'h02, 8'h11, 8'h22, 8'h30});
    wait_event(20, ev, got, cyc);
    check("tmo.tail_discarded", got, 0);
`else
    wait_event(70, ev, got, cyc);
    check("notmo.no_event", got, 0);
    check("notmo.err_code_kept", err_code, last_code);
    push('{8'h02, 8'h11, 8'h22, 8'h30});
    wait_event(20, ev, got, cyc);
    check("notmo.resumed_got", got, 1);
    compare_ev("notmo.resumed", ev, '{1'b0, 8'h01, 8'h02, 32'h0000_2211, last_code});
`endif

    // Reset in the middle of a payload
    push('{8'hA5, 8'h01, 8'h00, 8'h02});
    wait_event(20, ev, got, cyc);
    compare_ev("pre_rst.chk_err", ev, '{1'b1, 8'h00, 8'h00, 32'h0, ERR_CHK});
    push('{8'hA5, 8'h09, 8'h03, 8'h77});
    repeat (6) step();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.out_valid", out_valid, 0);
    check("mid_rst.err_pulse", err_pulse, 0);
    check("mid_rst.err_code", err_code, 0);
    check("mid_rst.out_cmd", out_cmd, 0);
    check("mid_rst.out_len", out_len, 0);
    check("mid_rst.out_payload", out_payload, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q = {};
    drive_fifo();
    push('{8'hA5, 8'h0C, 8'h01, 8'h5A, 8'h57});
    wait_event(20, ev, got, cyc);
    check("post_rst.got", got, 1);
    compare_ev("post_rst", ev, '{1'b0, 8'h0C, 8'h01, 32'h0000_005A, ERR_NONE});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
Consumes raw bytes from the RX-side UART FIFO and reassembles them into framed commands: SYNC, CMD, LEN, payload, checksum. Sits directly downstream of the RX FIFO, in place of the byte-echo path. Presents one decoded command at a time on a valid/ready interface to the debug/control logic. Reports malformed frames with a one-cycle error pulse and a sticky error code.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
MAX_LEN, 4, maximum payload bytes; payload bus is MAX_LEN*8 bits.
TIMEOUT_CYCLES, 100000, inter-byte timeout in clock cycles; used only with the optional feature.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
fifo_empty  in  1  RX FIFO empty flag.
fifo_data  in  8  RX FIFO head byte; valid whenever fifo_empty=0 (first-word fall-through).
fifo_read  out  1  pop strobe; the byte is consumed in the cycle this is high.
out_valid  out  1  decoded frame available; held until accepted.
out_ready  in  1  consumer accepts the frame when high together with out_valid.
out_cmd  out  8  CMD byte.
out_len  out  8  payload length, 0..MAX_LEN.
out_payload  out  MAX_LEN*8  payload; byte i in bits [8i+7:8i]; unused bytes are 0.
err_pulse  out  1  one-cycle pulse on a frame error.
err_code  out  2  last error: 0 none, 1 LEN_ERR, 2 CHK_ERR, 3 TMO_ERR; sticky until the next error.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs, payload register, checksum accumulator and byte index cleared to 0.
- fifo_read = (state in IDLE, CMD, LEN, PAYLOAD, CHECK) and fifo_empty=0. Combinational. At most one byte per cycle. State advances on the same rising edge that pops the byte.
- IDLE: byte == SYNC_BYTE goes to CMD and clears chk. Any other byte is popped and discarded silently, with no error.
- CMD: latch out_cmd; chk = byte; go to LEN.
- LEN: chk ^= byte.
  - byte > MAX_LEN: err_pulse, err_code=1, go to IDLE.
  - byte == 0: go to CHECK.
  - Otherwise: clear the payload register, set idx=0, go to PAYLOAD.
- PAYLOAD: store the byte at lane idx; chk ^= byte; idx++. Go to CHECK when idx reaches len-1.
- CHECK: byte == chk goes to DONE with out_valid=1 on the next cycle. A mismatch raises err_pulse, sets err_code=2, and goes to IDLE.
- DONE: no pops. out_cmd, out_len and out_payload are stable while out_valid=1. When out_valid and out_ready are both high, clear out_valid and go to IDLE on the next edge. Backpressure stalls the decoder and leaves bytes in the FIFO.
- Latency: out_valid rises 1 cycle after the checksum byte is popped.
- out_ready while out_valid=0 is ignored.
- A SYNC_BYTE value appearing inside CMD, LEN or payload is data, not a resync.
- Reset mid-frame drops the partial frame with no error reported.

Optional Feature:
Macro UART_FRAME_TIMEOUT_EN.
- Defined: a counter clears on every pop and increments while state is CMD, LEN, PAYLOAD or CHECK and fifo_empty=1. On reaching TIMEOUT_CYCLES it raises err_pulse, sets err_code=3 and goes to IDLE. The counter is held at 0 in IDLE and DONE.
- Undefined: no counter; a partial frame waits forever. err_code never takes the value 3.

Decomposition:
- Shared package uart_frame_pkg holds:
  - state encoding (IDLE, CMD, LEN, PAYLOAD, CHECK, DONE);
  - error code constants (ERR_NONE, ERR_LEN, ERR_CHK, ERR_TMO);
  - default SYNC_BYTE.
- One sub-module, uart_frame_timeout (counter plus expiry compare), instantiated only under UART_FRAME_TIMEOUT_EN.

Test Plan:
1. Good frame. FIFO holds A5 01 02 11 22 30; out_ready=1. Required: out_valid for 1 cycle, out_cmd=01, out_len=02, out_payload=32'h0000_2211, err_pulse stays 0.
2. Bad checksum. Same frame with last byte 31. Required: err_pulse=1 for one cycle, err_code=2, out_valid stays 0, decoder back in IDLE.
3. Length error. A5 05 07, then A5 03 00 03. Required: first frame gives err_code=1 after the 07 byte; second gives out_valid with cmd=03, len=0, payload=0.
4. Garbage before sync. 00 FF 5A A5 02 01 44 47. Required: three bytes popped silently; out_cmd=02, out_len=01, out_payload=32'h0000_0044.
5. Backpressure. Two good frames queued, out_ready=0 for 20 cycles. Required: out_valid held and outputs stable; fifo_read=0 throughout. After out_ready=1, the second frame is decoded.
6. Timeout (macro defined, TIMEOUT_CYCLES=50) and reset. A5 01, then empty FIFO for 50 cycles: required err_code=3, pulse, IDLE. Without the macro, the same stimulus leaves no error and the state stays LEN. Asserting reset mid-PAYLOAD clears all outputs immediately.
